// File: rtl/dispatch_scheduler_if.sv
// rtl/dispatch_scheduler_if.sv - instruction/datapath handshake bundle for the dispatch scheduler
interface dispatch_scheduler_if #(
    parameter int WIDTH  = 16,
    parameter int COST_W = 4,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [COST_W-1:0] in_cost;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [COST_W-1:0] out_cost;
    logic              out_valid0;
    logic              out_valid1;
    logic              dp0_ready;
    logic              dp1_ready;
    logic              dp0_done;
    logic              dp1_done;
    logic [COST_W-1:0] dp0_done_cost;
    logic [COST_W-1:0] dp1_done_cost;
    logic [WIDTH-1:0]  workload0;
    logic [WIDTH-1:0]  workload1;
    logic              err;

    modport master (
        output in_valid, in_data, in_cost, dp0_ready, dp1_ready,
               dp0_done, dp1_done, dp0_done_cost, dp1_done_cost,
        input  in_ready, out_data, out_cost, out_valid0, out_valid1,
               workload0, workload1, err
    );

    modport slave (
        input  in_valid, in_data, in_cost, dp0_ready, dp1_ready,
               dp0_done, dp1_done, dp0_done_cost, dp1_done_cost,
        output in_ready, out_data, out_cost, out_valid0, out_valid1,
               workload0, workload1, err
    );
endinterface

// File: rtl/dispatch_scheduler.sv
// rtl/dispatch_scheduler.sv - one-entry holding register dispatching to the less-loaded of two datapaths
module dispatch_scheduler #(
    parameter int WIDTH  = 16,
    parameter int COST_W = 4,
    parameter int DATA_W = 32
) (
    input logic                clk,
    input logic                rst,
    dispatch_scheduler_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state_q;
    logic              tgt_q;
    logic              rr_q;
    logic              err_q;
    logic              ov0_q;
    logic              ov1_q;
    logic [DATA_W-1:0] data_q;
    logic [COST_W-1:0] cost_q;
    logic [WIDTH-1:0]  wl0_q;
    logic [WIDTH-1:0]  wl1_q;

    logic              sel_ready;
    logic              handoff;
    logic              in_ready;
    logic              accept;
    logic              tie;
    logic              pick;
    logic [COST_W-1:0] add0, add1, sub0, sub1;
    logic [WIDTH:0]    wl0_d, wl1_d;

    function automatic logic [WIDTH:0] ext(input logic [COST_W-1:0] x);
        return {{(WIDTH+1-COST_W){1'b0}}, x};
    endfunction

    // Returns {range_error, saturated_value}; add and subtract are netted before clamping.
    function automatic logic [WIDTH:0] upd(input logic [WIDTH-1:0]  cur,
                                           input logic [COST_W-1:0] add,
                                           input logic [COST_W-1:0] sub);
        logic [WIDTH:0] sum;
        sum = {1'b0, cur} + ext(add);
        if (sum < ext(sub)) begin
            return {1'b1, {WIDTH{1'b0}}};
        end
        sum = sum - ext(sub);
        if (sum[WIDTH]) begin
            return {1'b1, {WIDTH{1'b1}}};
        end
        return {1'b0, sum[WIDTH-1:0]};
    endfunction

    always_comb begin
        sel_ready = tgt_q ? bus.dp1_ready : bus.dp0_ready;
        handoff   = (state_q == FULL) && sel_ready;
        in_ready  = !rst && ((state_q == EMPTY) || handoff);
        accept    = bus.in_valid && in_ready;
        tie       = (wl0_q == wl1_q);
        pick      = tie ? rr_q : (wl0_q > wl1_q);
        add0      = (accept && !pick) ? bus.in_cost : '0;
        add1      = (accept &&  pick) ? bus.in_cost : '0;
        sub0      = bus.dp0_done ? bus.dp0_done_cost : '0;
        sub1      = bus.dp1_done ? bus.dp1_done_cost : '0;
        wl0_d     = upd(wl0_q, add0, sub0);
        wl1_d     = upd(wl1_q, add1, sub1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            tgt_q   <= 1'b0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
            ov0_q   <= 1'b0;
            ov1_q   <= 1'b0;
            data_q  <= '0;
            cost_q  <= '0;
            wl0_q   <= '0;
            wl1_q   <= '0;
        end else begin
            wl0_q <= wl0_d[WIDTH-1:0];
            wl1_q <= wl1_d[WIDTH-1:0];
            err_q <= err_q | wl0_d[WIDTH] | wl1_d[WIDTH];
            if (accept) begin
                state_q <= FULL;
                data_q  <= bus.in_data;
                cost_q  <= bus.in_cost;
                tgt_q   <= pick;
                ov0_q   <= !pick;
                ov1_q   <= pick;
                if (tie) begin
                    rr_q <= !rr_q;
                end
            end else if (handoff) begin
                state_q <= EMPTY;
                ov0_q   <= 1'b0;
                ov1_q   <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_data   = data_q;
    assign bus.out_cost   = cost_q;
    assign bus.out_valid0 = ov0_q;
    assign bus.out_valid1 = ov1_q;
    assign bus.workload0  = wl0_q;
    assign bus.workload1  = wl1_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb/tb_dispatch_scheduler.sv - scoreboard bench for dispatch_scheduler with 4-bit workload counters
module tb_dispatch_scheduler;
    localparam int WIDTH  = 4;
    localparam int COST_W = 4;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [DATA_W+COST_W:0] exp_q[$];

    dispatch_scheduler_if #(.WIDTH(WIDTH), .COST_W(COST_W), .DATA_W(DATA_W)) dif ();

    dispatch_scheduler #(.WIDTH(WIDTH), .COST_W(COST_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Handed-off instructions are compared against the queue of expected {dp, data, cost}.
    always @(negedge clk) begin
        if (!rst) begin
            if (dif.out_valid0 && dif.out_valid1) check("both_valid", 1, 0);
            if ((dif.out_valid0 && dif.dp0_ready) || (dif.out_valid1 && dif.dp1_ready)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handoff", {31'd0, dif.out_valid1}, 32'hffff_ffff);
                end else begin
                    logic [DATA_W+COST_W:0] e;
                    e = exp_q.pop_front();
                    check("handoff_dp",   {31'd0, dif.out_valid1}, {31'd0, e[DATA_W+COST_W]});
                    check("handoff_data", dif.out_data, e[DATA_W+COST_W-1:COST_W]);
                    check("handoff_cost", {28'd0, dif.out_cost}, {28'd0, e[COST_W-1:0]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] d, input logic [3:0] c, input logic dp);
        dif.in_valid = 1'b1;
        dif.in_data  = d;
        dif.in_cost  = c;
        exp_q.push_back({dp, d, c});
        tick();
        dif.in_valid = 1'b0;
    endtask

    task automatic retire(input logic [3:0] c0, input logic [3:0] c1);
        dif.dp0_done      = (c0 != 0);
        dif.dp1_done      = (c1 != 0);
        dif.dp0_done_cost = c0;
        dif.dp1_done_cost = c1;
        tick();
        dif.dp0_done = 1'b0;
        dif.dp1_done = 1'b0;
    endtask

    task automatic wl(input string name, input logic [3:0] w0, input logic [3:0] w1);
        check({name, "_wl0"}, {28'd0, dif.workload0}, {28'd0, w0});
        check({name, "_wl1"}, {28'd0, dif.workload1}, {28'd0, w1});
    endtask

    initial begin
        dif.in_valid = 0; dif.in_data = 0; dif.in_cost = 0;
        dif.dp0_ready = 0; dif.dp1_ready = 0;
        dif.dp0_done = 0; dif.dp1_done = 0;
        dif.dp0_done_cost = 0; dif.dp1_done_cost = 0;

        tick(); tick();
        check("rst_in_ready", {31'd0, dif.in_ready}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, dif.in_ready}, 1);
        check("rst_ov0", {31'd0, dif.out_valid0}, 0);
        check("rst_ov1", {31'd0, dif.out_valid1}, 0);
        check("rst_err", {31'd0, dif.err}, 0);
        wl("rst", 0, 0);

        // Tie alternation and least-loaded routing, back-to-back with both datapaths ready.
        dif.dp0_ready = 1; dif.dp1_ready = 1;
        accept(32'hA1, 3, 0);
        wl("a1", 3, 0);
        check("a1_lat_ov0", {31'd0, dif.out_valid0}, 1);
        accept(32'hA2, 3, 1);
        wl("a2", 3, 3);
        accept(32'hA3, 3, 1);
        wl("a3", 3, 6);
        accept(32'hA4, 2, 0);
        wl("a4", 5, 6);
        tick();
        check("a_idle_ov0", {31'd0, dif.out_valid0}, 0);
        check("a_idle_ov1", {31'd0, dif.out_valid1}, 0);
        retire(5, 6);
        wl("a_ret", 0, 0);

        // Backpressure on dp0 with a second instruction waiting.
        dif.dp0_ready = 0; dif.dp1_ready = 0;
        accept(32'hB1, 5, 0);
        dif.in_valid = 1; dif.in_data = 32'hB2; dif.in_cost = 2;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", {31'd0, dif.in_ready}, 0);
            check("bp_ov0", {31'd0, dif.out_valid0}, 1);
            check("bp_data", dif.out_data, 32'hB1);
            check("bp_cost", {28'd0, dif.out_cost}, 5);
            tick();
        end
        dif.dp0_ready = 1;
        #1;
        check("bp_release_ready", {31'd0, dif.in_ready}, 1);
        exp_q.push_back({1'b1, 32'hB2, 4'd2});
        tick();
        dif.in_valid = 0; dif.dp0_ready = 0;
        check("b2_ov1", {31'd0, dif.out_valid1}, 1);
        check("b2_data", dif.out_data, 32'hB2);
        wl("b2", 5, 2);
        dif.dp1_ready = 1;
        tick();

        // Net add/subtract on dp1.
        dif.dp0_ready = 1;
        accept(32'hC1, 7, 1);
        accept(32'hC2, 7, 0);
        accept(32'hC3, 1, 1);
        wl("c3", 12, 10);
        dif.dp1_done = 1; dif.dp1_done_cost = 6;
        accept(32'hC4, 4, 1);
        dif.dp1_done = 0;
        wl("c4_net", 12, 8);
        tick();

        // Overflow saturation.
        retire(12, 8);
        wl("e_pre", 0, 0);
        accept(32'hE1, 15, 1);
        accept(32'hE2, 14, 0);
        wl("e2", 14, 15);
        check("e2_err", {31'd0, dif.err}, 0);
        accept(32'hE3, 3, 0);
        wl("e3_sat", 15, 15);
        check("e3_err", {31'd0, dif.err}, 1);
        tick();

        // Reset while holding an instruction.
        dif.dp0_ready = 0; dif.dp1_ready = 0;
        retire(8, 15);
        wl("f_pre", 7, 0);
        accept(32'hF1, 2, 1);
        check("f1_ov1", {31'd0, dif.out_valid1}, 1);
        rst = 1;
        dif.in_valid = 1; dif.in_data = 32'hDEAD; dif.in_cost = 9;
        dif.dp0_done = 1; dif.dp0_done_cost = 1;
        tick();
        check("frst_in_ready", {31'd0, dif.in_ready}, 0);
        check("frst_ov0", {31'd0, dif.out_valid0}, 0);
        check("frst_ov1", {31'd0, dif.out_valid1}, 0);
        check("frst_data", dif.out_data, 0);
        check("frst_cost", {28'd0, dif.out_cost}, 0);
        check("frst_err", {31'd0, dif.err}, 0);
        wl("frst", 0, 0);
        rst = 0;
        dif.in_valid = 0; dif.dp0_done = 0;
        exp_q.delete();
        dif.dp0_ready = 1; dif.dp1_ready = 1;
        tick(); tick(); tick();
        check("f_after_ov1", {31'd0, dif.out_valid1}, 0);
        wl("f_after", 0, 0);

        // Underflow clamp and sticky error.
        accept(32'hD1, 2, 0);
        wl("d1", 2, 0);
        tick();
        retire(5, 0);
        wl("d_uf", 0, 0);
        check("d_uf_err", {31'd0, dif.err}, 1);
        tick(); tick();
        check("d_err_sticky", {31'd0, dif.err}, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
